uart_rxd: RTL and testbench

- UART receiver paired with the team's TxD transmitter.
- Frame format is 8N1: start bit 0, 8 data bits LSB-first, stop bit 1.
- Synchronises the asynchronous RxD line, detects the start edge, samples each bit at mid-period and presents the received byte with a one-cycle valid strobe.
- Reports framing errors and line-break conditions.
- Sits between the pad and the MCU peripheral bus register.

---
 rtl/uart_rxd.sv | 141 ++++++++++++++
 tb/tb_uart_rxd.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rxd.sv
// 8N1 UART receiver: 2-FF synchronised RxD, mid-bit sampling, one-cycle valid and
// framing-error strobes, and a break state that waits out a held-low line.
module uart_rxd #(
    parameter int unsigned CLKS_PER_BIT = 5209
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign data          = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rxd.sv
// Scoreboard bench for uart_rxd: stimulus pushes expected bytes, a negedge monitor
// pops and compares on every data_valid and audits framing_error pulses.
module tb_uart_rxd;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ferr_seen = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];
    int         valid_times[$];

    uart_rxd #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .RxD           (RxD),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid === 1'b1) begin
                valid_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got data %0h want no pulse (cycle %0d)",
                             data, cyc);
                end else begin
                    chk("data", {24'h0, data}, {24'h0, exp_q[0]});
                    last_good = exp_q.pop_front();
                end
                chk("busy_at_valid", {31'h0, busy}, 32'h0);
                chk("ferr_with_valid", {31'h0, framing_error}, 32'h0);
            end
            if (framing_error === 1'b1) begin
                ferr_seen++;
                chk("data_at_ferr", {24'h0, data}, {24'h0, last_good});
            end
        end
    end

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b5a;
        // Reset state, asserted mid-cycle.
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_ferr", {31'h0, framing_error}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_data", {24'h0, data}, 32'h0);

        // Single frame.
        valid_times.delete();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        drain(4 * CPB);
        chk("single_pulses", valid_times.size(), 1);
        chk("single_hold", {24'h0, data}, 32'hA5);

        // Back-to-back frames with zero idle gap.
        valid_times.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        drain(4 * CPB);
        chk("b2b_pulses", valid_times.size(), 3);
        if (valid_times.size() == 3) begin
            chk("b2b_gap1", valid_times[1] - valid_times[0], 10 * CPB);
            chk("b2b_gap2", valid_times[2] - valid_times[1], 10 * CPB);
        end

        // Start glitch: 5 clk low is shorter than half a bit.
        valid_times.delete();
        RxD = 1'b0;
        repeat (5) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("glitch_busy", {31'h0, busy}, 32'h0);
        chk("glitch_data", {24'h0, data}, 32'h55);
        chk("glitch_pulses", valid_times.size(), 0);

        // Framing error followed by a 40-bit break, then a good frame.
        send_frame(8'h3C, 1'b0);
        repeat (40 * CPB) @(posedge clk);
        #1;
        chk("break_busy", {31'h0, busy}, 32'h1);
        chk("break_ferr_count", ferr_seen, 1);
        chk("break_data", {24'h0, data}, 32'h55);
        RxD = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_exit_busy", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        drain(4 * CPB);
        chk("after_break_data", {24'h0, data}, 32'h81);

        // Reset during data bit 4 of 0x5A.
        b5a = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b5a[i]);
        RxD = b5a[4];
        repeat (CPB / 2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_data", {24'h0, data}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        RxD = 1'b1;
        last_good = 8'h00;
        repeat (2 * CPB) @(posedge clk);
        #1;
        valid_times.delete();
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        drain(4 * CPB);
        chk("midrst_pulses", valid_times.size(), 1);
        chk("final_data", {24'h0, data}, 32'hC3);
        chk("final_ferr_count", ferr_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
